// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream (PRGA) stage: swaps S entries, XORs each keystream byte with
// a ciphertext ROM byte and writes the plaintext to the result RAM.
// Optional feature macro: RC4_CHAR_CHECK_EN (abort with fail=1 on a plaintext
// byte outside 'a'..'z' / space).
module rc4_prga_decrypt #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              finish,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wen,
    input  logic [7:0]        s_q,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [ADDR_W-1:0] dec_address,
    output logic [7:0]        dec_data,
    output logic              dec_wen,
    output logic              fail
);

    localparam int unsigned BYTE_W = 8;
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

    typedef enum logic [4:0] {
        IDLE, INIT, INC_I,
        RD_SI, WT_SI, ST_SI, UPD_J,
        RD_SJ, WT_SJ, ST_SJ,
        SET_WJ, WR_SJ, SET_WI, WR_SI,
        RD_F, WT_F, ST_F,
        SET_D, WR_D, NEXT_K, DONE
    } state_t;

    state_t state, state_n;

    logic [BYTE_W-1:0] i_q, i_n;
    logic [BYTE_W-1:0] j_q, j_n;
    logic [BYTE_W-1:0] si_q, si_n;
    logic [BYTE_W-1:0] sj_q, sj_n;
    logic [BYTE_W-1:0] f_q, f_n;
    logic [BYTE_W-1:0] c_q, c_n;
    logic [ADDR_W-1:0] k_q, k_n;

    logic [BYTE_W-1:0] s_address_n, s_data_n, dec_data_n;
    logic [ADDR_W-1:0] rom_address_n, dec_address_n;
    logic              s_wen_n, dec_wen_n, finish_n, fail_n;

    logic [BYTE_W-1:0] plain_c;
    logic              plain_ok_c;

    // keystream byte XOR ciphertext byte
    assign plain_c = f_q ^ c_q;

`ifdef RC4_CHAR_CHECK_EN
    // acceptable plaintext: lowercase letter or space
    assign plain_ok_c = ((plain_c >= 8'h61) && (plain_c <= 8'h7A)) || (plain_c == 8'h20);
`else
    assign plain_ok_c = 1'b1;
`endif

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // next state, datapath updates and next registered outputs
    always_comb begin
        state_n       = state;
        i_n           = i_q;
        j_n           = j_q;
        si_n          = si_q;
        sj_n          = sj_q;
        f_n           = f_q;
        c_n           = c_q;
        k_n           = k_q;
        s_address_n   = s_address;
        s_data_n      = s_data;
        rom_address_n = rom_address;
        dec_address_n = dec_address;
        dec_data_n    = dec_data;
        s_wen_n       = 1'b0;
        dec_wen_n     = 1'b0;
        finish_n      = 1'b0;
        fail_n        = 1'b0;

        case (state)
            IDLE: if (start) state_n = INIT;
            INIT: begin
                i_n     = '0;
                j_n     = '0;
                k_n     = '0;
                state_n = INC_I;
            end
            INC_I: begin
                i_n     = i_q + BYTE_W'(1);
                state_n = RD_SI;
            end
            RD_SI: begin
                s_address_n = i_q;
                state_n     = WT_SI;
            end
            WT_SI: state_n = ST_SI;
            ST_SI: begin
                si_n    = s_q;
                state_n = UPD_J;
            end
            UPD_J: begin
                j_n     = j_q + si_q;
                state_n = RD_SJ;
            end
            RD_SJ: begin
                s_address_n = j_q;
                state_n     = WT_SJ;
            end
            WT_SJ: state_n = ST_SJ;
            ST_SJ: begin
                sj_n    = s_q;
                state_n = SET_WJ;
            end
            SET_WJ: begin
                s_address_n = j_q;
                s_data_n    = si_q;
                s_wen_n     = 1'b1;
                state_n     = WR_SJ;
            end
            WR_SJ: state_n = SET_WI;
            // S[i] written after S[j] so that i==j leaves the original value
            SET_WI: begin
                s_address_n = i_q;
                s_data_n    = sj_q;
                s_wen_n     = 1'b1;
                state_n     = WR_SI;
            end
            WR_SI: state_n = RD_F;
            RD_F: begin
                s_address_n   = si_q + sj_q;
                rom_address_n = k_q;
                state_n       = WT_F;
            end
            WT_F: state_n = ST_F;
            ST_F: begin
                f_n     = s_q;
                c_n     = rom_q;
                state_n = SET_D;
            end
            SET_D: begin
                if (plain_ok_c) begin
                    dec_address_n = k_q;
                    dec_data_n    = plain_c;
                    dec_wen_n     = 1'b1;
                    state_n       = WR_D;
                end else begin
                    finish_n = 1'b1;
                    fail_n   = 1'b1;
                    state_n  = DONE;
                end
            end
            WR_D: state_n = NEXT_K;
            NEXT_K: begin
                if (k_q == LAST_K) begin
                    finish_n = 1'b1;
                    state_n  = DONE;
                end else begin
                    k_n     = k_q + ADDR_W'(1);
                    state_n = INC_I;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_q         <= '0;
            j_q         <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            f_q         <= '0;
            c_q         <= '0;
            k_q         <= '0;
            s_address   <= '0;
            s_data      <= '0;
            s_wen       <= 1'b0;
            rom_address <= '0;
            dec_address <= '0;
            dec_data    <= '0;
            dec_wen     <= 1'b0;
            finish      <= 1'b0;
            fail        <= 1'b0;
        end else begin
            i_q         <= i_n;
            j_q         <= j_n;
            si_q        <= si_n;
            sj_q        <= sj_n;
            f_q         <= f_n;
            c_q         <= c_n;
            k_q         <= k_n;
            s_address   <= s_address_n;
            s_data      <= s_data_n;
            s_wen       <= s_wen_n;
            rom_address <= rom_address_n;
            dec_address <= dec_address_n;
            dec_data    <= dec_data_n;
            dec_wen     <= dec_wen_n;
            finish      <= finish_n;
            fail        <= fail_n;
        end
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt: two instances (MSG_LEN 2 and 9) with
// behavioural S RAM, ciphertext ROM and result RAM, plus a write-bus monitor.
module tb_rc4_prga_decrypt;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // instance A: MSG_LEN=2
    logic       start_a = 1'b0, finish_a, s_wen_a, dec_wen_a, fail_a;
    logic [7:0] s_address_a, s_data_a, s_q_a, rom_q_a, dec_data_a;
    logic [4:0] rom_address_a, dec_address_a;
    logic [7:0] s_mem_a [256];
    logic [7:0] rom_a   [32];
    logic [7:0] dec_a   [32];

    // instance B: MSG_LEN=9
    logic       start_b = 1'b0, finish_b, s_wen_b, dec_wen_b, fail_b;
    logic [7:0] s_address_b, s_data_b, s_q_b, rom_q_b, dec_data_b;
    logic [4:0] rom_address_b, dec_address_b;
    logic [7:0] s_mem_b [256];
    logic [7:0] rom_b   [32];
    logic [7:0] dec_b   [32];

    rc4_prga_decrypt #(.MSG_LEN(2), .ADDR_W(5)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .finish(finish_a),
        .s_address(s_address_a), .s_data(s_data_a), .s_wen(s_wen_a), .s_q(s_q_a),
        .rom_address(rom_address_a), .rom_q(rom_q_a),
        .dec_address(dec_address_a), .dec_data(dec_data_a), .dec_wen(dec_wen_a),
        .fail(fail_a)
    );

    rc4_prga_decrypt #(.MSG_LEN(9), .ADDR_W(5)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .finish(finish_b),
        .s_address(s_address_b), .s_data(s_data_b), .s_wen(s_wen_b), .s_q(s_q_b),
        .rom_address(rom_address_b), .rom_q(rom_q_b),
        .dec_address(dec_address_b), .dec_data(dec_data_b), .dec_wen(dec_wen_b),
        .fail(fail_b)
    );

    // synchronous memories: one-cycle read, write on wen
    always @(posedge clk) begin
        s_q_a   <= s_mem_a[s_address_a];
        rom_q_a <= rom_a[rom_address_a];
        if (s_wen_a)   s_mem_a[s_address_a] = s_data_a;
        if (dec_wen_a) dec_a[dec_address_a] = dec_data_a;
        s_q_b   <= s_mem_b[s_address_b];
        rom_q_b <= rom_b[rom_address_b];
        if (s_wen_b)   s_mem_b[s_address_b] = s_data_b;
        if (dec_wen_b) dec_b[dec_address_b] = dec_data_b;
    end

    // write-bus monitor state
    int         swp_a = 0, dwp_a = 0, swp_b = 0, dwp_b = 0;
    logic       pa_sw = 0, pa_dw = 0, pb_sw = 0, pb_dw = 0;
    logic [7:0] pa_sadr, pa_sdat, pa_ddat, pb_sadr, pb_sdat, pb_ddat;
    logic [4:0] pa_dadr, pb_dadr;

    // wen never overlap; one-cycle pulses; address/data held through the pulse
    always @(negedge clk) begin
        if (!reset) begin
            pa_sw = 0; pa_dw = 0; pb_sw = 0; pb_dw = 0;
        end else begin
            if (s_wen_a || dec_wen_a) begin
                n_vec++;
                if (s_wen_a && dec_wen_a) begin
                    n_mis++; $display("FAIL mon_a_overlap: s_wen=%b dec_wen=%b required not both 1", s_wen_a, dec_wen_a);
                end
            end
            if (s_wen_b || dec_wen_b) begin
                n_vec++;
                if (s_wen_b && dec_wen_b) begin
                    n_mis++; $display("FAIL mon_b_overlap: s_wen=%b dec_wen=%b required not both 1", s_wen_b, dec_wen_b);
                end
            end
            if (pa_sw) begin
                n_vec++;
                if (s_wen_a || s_address_a !== pa_sadr || s_data_a !== pa_sdat) begin
                    n_mis++; $display("FAIL mon_a_spulse: wen=%b adr=%h dat=%h required 0 %h %h", s_wen_a, s_address_a, s_data_a, pa_sadr, pa_sdat);
                end
            end
            if (pa_dw) begin
                n_vec++;
                if (dec_wen_a || dec_address_a !== pa_dadr || dec_data_a !== pa_ddat) begin
                    n_mis++; $display("FAIL mon_a_dpulse: wen=%b adr=%h dat=%h required 0 %h %h", dec_wen_a, dec_address_a, dec_data_a, pa_dadr, pa_ddat);
                end
            end
            if (pb_sw) begin
                n_vec++;
                if (s_wen_b || s_address_b !== pb_sadr || s_data_b !== pb_sdat) begin
                    n_mis++; $display("FAIL mon_b_spulse: wen=%b adr=%h dat=%h required 0 %h %h", s_wen_b, s_address_b, s_data_b, pb_sadr, pb_sdat);
                end
            end
            if (pb_dw) begin
                n_vec++;
                if (dec_wen_b || dec_address_b !== pb_dadr || dec_data_b !== pb_ddat) begin
                    n_mis++; $display("FAIL mon_b_dpulse: wen=%b adr=%h dat=%h required 0 %h %h", dec_wen_b, dec_address_b, dec_data_b, pb_dadr, pb_ddat);
                end
            end
            if (s_wen_a)   swp_a++;
            if (dec_wen_a) dwp_a++;
            if (s_wen_b)   swp_b++;
            if (dec_wen_b) dwp_b++;
            pa_sw = s_wen_a; pa_sadr = s_address_a; pa_sdat = s_data_a;
            pa_dw = dec_wen_a; pa_dadr = dec_address_a; pa_ddat = dec_data_a;
            pb_sw = s_wen_b; pb_sadr = s_address_b; pb_sdat = s_data_b;
            pb_dw = dec_wen_b; pb_dadr = dec_address_b; pb_ddat = dec_data_b;
        end
    end

    task automatic drive(input bit sel, input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // start a run; optionally re-pulse start at edge pulse_at; watch finish for limit edges
    task automatic run_dut(input bit sel, input int pulse_at, input int limit,
                           output int fin_cyc, output int fin_cnt, output logic fail_seen);
        fin_cyc = 0; fin_cnt = 0; fail_seen = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1);
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk);
            @(negedge clk);
            drive(sel, (c + 1) == pulse_at);
            if (sel ? finish_b : finish_a) begin
                fin_cnt++;
                if (fin_cyc == 0) fin_cyc = c;
                fail_seen = sel ? fail_b : fail_a;
            end
        end
        drive(sel, 1'b0);
    endtask

    task automatic load_ident_a();
        for (int x = 0; x < 256; x++) s_mem_a[x] = 8'(x);
        for (int x = 0; x < 32; x++) begin rom_a[x] = 8'h00; dec_a[x] = 8'hEE; end
    endtask

    // S built by the standard key schedule for key "Key"; ciphertext of "Plaintext"
    task automatic load_ksa_b();
        logic [7:0] key [3];
        logic [7:0] cip [9];
        logic [7:0] jj, t;
        key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
        cip[0] = 8'hBB; cip[1] = 8'hF3; cip[2] = 8'h16; cip[3] = 8'hE8; cip[4] = 8'hD9;
        cip[5] = 8'h40; cip[6] = 8'hAF; cip[7] = 8'h0A; cip[8] = 8'hD3;
        for (int x = 0; x < 256; x++) s_mem_b[x] = 8'(x);
        jj = 8'h00;
        for (int x = 0; x < 256; x++) begin
            jj = jj + s_mem_b[x] + key[x % 3];
            t = s_mem_b[x]; s_mem_b[x] = s_mem_b[jj]; s_mem_b[jj] = t;
        end
        for (int x = 0; x < 32; x++) begin rom_b[x] = (x < 9) ? cip[x] : 8'h00; dec_b[x] = 8'hEE; end
    endtask

    task automatic check_plaintext_b(input string tag);
        logic [7:0] exp [9];
        exp[0] = 8'h50; exp[1] = 8'h6C; exp[2] = 8'h61; exp[3] = 8'h69; exp[4] = 8'h6E;
        exp[5] = 8'h74; exp[6] = 8'h65; exp[7] = 8'h78; exp[8] = 8'h74;
        for (int x = 0; x < 9; x++) begin
            n_vec++;
            if (dec_b[x] !== exp[x]) begin
                n_mis++; $display("FAIL %s_dec%0d: got %h expected %h", tag, x, dec_b[x], exp[x]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({finish_a, fail_a, s_wen_a, dec_wen_a, s_address_a, s_data_a, rom_address_a, dec_address_a, dec_data_a} !== '0) begin
            n_mis++; $display("FAIL reset_a_outputs: got nonzero outputs, expected all 0");
        end
        n_vec++;
        if ({finish_b, fail_b, s_wen_b, dec_wen_b, s_address_b, s_data_b, rom_address_b, dec_address_b, dec_data_b} !== '0) begin
            n_mis++; $display("FAIL reset_b_outputs: got nonzero outputs, expected all 0");
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({finish_a, s_wen_a, dec_wen_a, finish_b, s_wen_b, dec_wen_b} !== 6'b0) begin
            n_mis++; $display("FAIL idle_quiet: got strobes %b expected 000000", {finish_a, s_wen_a, dec_wen_a, finish_b, s_wen_b, dec_wen_b});
        end
    endtask

    task automatic test_identity();
        int fc, fn; logic fl;
        load_ident_a();
        swp_a = 0; dwp_a = 0;
        run_dut(1'b0, 0, 45, fc, fn, fl);
        n_vec++; if (dec_a[0] !== 8'h02) begin n_mis++; $display("FAIL ident_dec0: got %h expected 02", dec_a[0]); end
        n_vec++; if (dec_a[1] !== 8'h05) begin n_mis++; $display("FAIL ident_dec1: got %h expected 05", dec_a[1]); end
        n_vec++; if (s_mem_a[2] !== 8'h03) begin n_mis++; $display("FAIL ident_s2: got %h expected 03", s_mem_a[2]); end
        n_vec++; if (s_mem_a[3] !== 8'h02) begin n_mis++; $display("FAIL ident_s3: got %h expected 02", s_mem_a[3]); end
        n_vec++; if (fc !== 38) begin n_mis++; $display("FAIL ident_latency: got %0d expected 38", fc); end
        n_vec++; if (fn !== 1) begin n_mis++; $display("FAIL ident_finish_count: got %0d expected 1", fn); end
        n_vec++; if (fl !== 1'b0) begin n_mis++; $display("FAIL ident_fail: got %b expected 0", fl); end
        n_vec++; if (swp_a !== 4 || dwp_a !== 2) begin n_mis++; $display("FAIL ident_wen_pulses: got s=%0d d=%0d expected s=4 d=2", swp_a, dwp_a); end
    endtask

    // start held high across DONE: a second run starts with S carried over
    task automatic test_carry();
        int fn, f1, f2;
        fn = 0; f1 = 0; f2 = 0;
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 40) start_a = 1'b0;
            if (finish_a) begin
                fn++;
                if (fn == 1) f1 = c;
                else if (fn == 2) f2 = c;
            end
        end
        start_a = 1'b0;
        n_vec++; if (fn !== 2) begin n_mis++; $display("FAIL carry_finish_count: got %0d expected 2", fn); end
        n_vec++; if (f1 !== 38 || f2 !== 77) begin n_mis++; $display("FAIL carry_finish_cycles: got %0d,%0d expected 38,77", f1, f2); end
        n_vec++; if (dec_a[0] !== 8'h04) begin n_mis++; $display("FAIL carry_dec0: got %h expected 04", dec_a[0]); end
        n_vec++; if (dec_a[1] !== 8'h09) begin n_mis++; $display("FAIL carry_dec1: got %h expected 09", dec_a[1]); end
    endtask

    task automatic test_plaintext();
        int fc, fn; logic fl;
        load_ksa_b();
        swp_b = 0; dwp_b = 0;
        run_dut(1'b1, 0, 175, fc, fn, fl);
        check_plaintext_b("ptxt");
        n_vec++; if (fc !== 164) begin n_mis++; $display("FAIL ptxt_latency: got %0d expected 164", fc); end
        n_vec++; if (fn !== 1) begin n_mis++; $display("FAIL ptxt_finish_count: got %0d expected 1", fn); end
        n_vec++; if (fl !== 1'b0) begin n_mis++; $display("FAIL ptxt_fail: got %b expected 0", fl); end
        n_vec++; if (swp_b !== 18 || dwp_b !== 9) begin n_mis++; $display("FAIL ptxt_wen_pulses: got s=%0d d=%0d expected s=18 d=9", swp_b, dwp_b); end
    endtask

    task automatic test_back_to_back_start();
        int fc, fn; logic fl;
        load_ksa_b();
        run_dut(1'b1, 50, 175, fc, fn, fl);
        check_plaintext_b("restart");
        n_vec++; if (fc !== 164) begin n_mis++; $display("FAIL restart_latency: got %0d expected 164", fc); end
        n_vec++; if (fn !== 1) begin n_mis++; $display("FAIL restart_finish_count: got %0d expected 1", fn); end
    endtask

    // reset during WR_SJ of byte 3 (edge 2 + 18*3 + 9 = 65)
    task automatic test_reset_midrun();
        int fc, fn; logic fl; int seen;
        load_ksa_b();
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        repeat (64) @(posedge clk);
        #1;
        n_vec++; if (s_wen_b !== 1'b1) begin n_mis++; $display("FAIL midrst_in_wr_sj: s_wen got %b expected 1", s_wen_b); end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({finish_b, fail_b, s_wen_b, dec_wen_b, s_address_b, s_data_b, rom_address_b, dec_address_b, dec_data_b} !== '0) begin
            n_mis++; $display("FAIL midrst_outputs: got nonzero outputs, expected all 0");
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({finish_b, s_wen_b, s_address_b, s_data_b} !== '0) begin
            n_mis++; $display("FAIL midrst_after_edge: got nonzero outputs, expected all 0");
        end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (finish_b) seen++;
        end
        n_vec++; if (seen !== 0) begin n_mis++; $display("FAIL midrst_no_finish: got %0d finish pulses expected 0", seen); end
        load_ksa_b();
        run_dut(1'b1, 0, 175, fc, fn, fl);
        check_plaintext_b("midrst_fresh");
        n_vec++; if (fc !== 164 || fn !== 1) begin n_mis++; $display("FAIL midrst_fresh_finish: got cyc %0d cnt %0d expected 164 1", fc, fn); end
    endtask

    task automatic test_char_check();
        int fc, fn; logic fl;
        load_ident_a();
        rom_a[0] = 8'h63;
        rom_a[1] = 8'h00;
        swp_a = 0; dwp_a = 0;
        run_dut(1'b0, 0, 45, fc, fn, fl);
        n_vec++; if (dec_a[0] !== 8'h61) begin n_mis++; $display("FAIL chk_dec0: got %h expected 61", dec_a[0]); end
        n_vec++; if (fn !== 1) begin n_mis++; $display("FAIL chk_finish_count: got %0d expected 1", fn); end
`ifdef RC4_CHAR_CHECK_EN
        n_vec++; if (dec_a[1] !== 8'hEE) begin n_mis++; $display("FAIL chk_dec1_untouched: got %h expected EE", dec_a[1]); end
        n_vec++; if (fl !== 1'b1) begin n_mis++; $display("FAIL chk_fail: got %b expected 1", fl); end
        n_vec++; if (fc !== 36) begin n_mis++; $display("FAIL chk_latency: got %0d expected 36", fc); end
        n_vec++; if (dwp_a !== 1) begin n_mis++; $display("FAIL chk_dec_pulses: got %0d expected 1", dwp_a); end
`else
        n_vec++; if (dec_a[1] !== 8'h05) begin n_mis++; $display("FAIL chk_dec1: got %h expected 05", dec_a[1]); end
        n_vec++; if (fl !== 1'b0) begin n_mis++; $display("FAIL chk_fail: got %b expected 0", fl); end
        n_vec++; if (fc !== 38) begin n_mis++; $display("FAIL chk_latency: got %0d expected 38", fc); end
        n_vec++; if (dwp_a !== 2) begin n_mis++; $display("FAIL chk_dec_pulses: got %0d expected 2", dwp_a); end
`endif
    endtask

    initial begin
        test_reset();
`ifndef RC4_CHAR_CHECK_EN
        test_identity();
        test_carry();
        test_plaintext();
        test_back_to_back_start();
        test_reset_midrun();
`endif
        test_char_check();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
